// File: rtl/uart_rx_fsm_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm_if
//   Bundles the serial-side inputs and the received-word outputs of the UART
//   receiver so the core and its environment share one connection point.
//
//   Signals:
//     sample_tick  one-clk enable at OVERSAMPLE x baud
//     rx_in        raw serial line (asynchronous to clk, idles high)
//     rx_data      last received data word
//     rx_valid     one-clk pulse when rx_data / error flags are updated
//     parity_err   parity mismatch on the last frame
//     frame_err    stop bit sampled low on the last frame
//     rx_busy      frame in progress or line recovery in progress
//
//   Modports:
//     master  environment side (drives tick and line, observes results)
//     slave   receiver side
// -----------------------------------------------------------------------------
interface uart_rx_fsm_if #(
    parameter int DATA_BITS = 8
);
    logic                 sample_tick;
    logic                 rx_in;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rx_busy;

    modport master (
        output sample_tick,
        output rx_in,
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  sample_tick,
        input  rx_in,
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// uart_rx_fsm
//   UART receiver. Frame format: start bit (0), DATA_BITS data bits LSB first,
//   one parity bit, one stop bit (1). The line is oversampled by sample_tick
//   and every bit is sampled at its midpoint. Each frame produces a one-clk
//   rx_valid pulse together with the data word and parity/framing flags; the
//   word is delivered even when a flag is raised.
//
//   Ports:
//     clk   clock
//     rst   asynchronous, active-high reset
//     bus   uart_rx_fsm_if.slave (sample_tick, rx_in in; rx_data, rx_valid,
//           parity_err, frame_err, rx_busy out)
//
//   Parameters:
//     DATA_BITS   data bits per frame (5..8)
//     OVERSAMPLE  sample_tick pulses per bit period (even, >= 4)
//     PARITY_ODD  0 = even parity expected, 1 = odd parity expected
// -----------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    uart_rx_fsm_if.slave     bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          ODD_PAR   = (PARITY_ODD != 0);

    // Elaboration-time parameter sanity.
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_rx_fsm: DATA_BITS must be in 5..8");
    end
    if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("uart_rx_fsm: OVERSAMPLE must be even and >= 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RECOVER
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]           sync_q,       sync_d;
    state_t               state_q,      state_d;
    logic [TW-1:0]        tick_cnt_q,   tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 par_bit_q,    par_bit_d;
    logic [DATA_BITS-1:0] rx_data_q,    rx_data_d;
    logic                 rx_valid_q,   rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;
    logic                 rx_busy_q,    rx_busy_d;

    // Synchronised line: second stage of the two-flop synchroniser.
    logic rx_s;
    assign rx_s = sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Synchroniser resets to the idle line level so no false start
            // is seen on reset release.
            sync_q       <= 2'b11;
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bit_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bit_q    <= par_bit_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        sync_d       = {sync_q[0], bus.rx_in};
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bit_d    = par_bit_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        // Everything below only moves on a tick; without one the whole
        // receiver simply holds.
        if (bus.sample_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end

                S_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        // Mid start bit: a line back high here was only a
                        // glitch, so drop it without producing anything.
                        tick_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d   = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // LSB arrives first, so shifting right with the new
                        // bit at the MSB leaves bit 0 in place after the
                        // last sample.
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        tick_cnt_d = '0;
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = S_PARITY;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        par_bit_d  = rx_s;
                        tick_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        // Frame complete at mid stop bit; leaving here
                        // leaves half a bit to catch a back-to-back start.
                        rx_data_d    = shift_q;
                        parity_err_d = ((^shift_q) ^ par_bit_q) != ODD_PAR;
                        frame_err_d  = ~rx_s;
                        rx_valid_d   = 1'b1;
                        tick_cnt_d   = '0;
                        state_d      = rx_s ? S_IDLE : S_RECOVER;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end

                S_RECOVER: begin
                    // A held-low line (break) must return high before a new
                    // start bit can be recognised.
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d    = S_IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end

        // Registered from the next state so rx_busy drops on the same clk
        // that rx_valid rises when a good frame ends.
        rx_busy_d = (state_d != S_IDLE);
    end

    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.rx_busy    = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fsm
//   Drives two receivers (even and odd parity) from one serial line. Expected
//   results come from the frame content alone: the data byte, the parity rule
//   and the stop bit level.
// -----------------------------------------------------------------------------
module tb_uart_rx_fsm;

    localparam int OS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_line = 1'b1;
    logic tick = 1'b0;
    int   tick_div = 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    uart_rx_fsm_if #(.DATA_BITS(8)) if0 ();
    uart_rx_fsm_if #(.DATA_BITS(8)) if1 ();

    assign if0.sample_tick = tick;
    assign if0.rx_in       = rx_line;
    assign if1.sample_tick = tick;
    assign if1.rx_in       = rx_line;

    uart_rx_fsm #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    uart_rx_fsm #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_ODD(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // sample_tick: every clk when tick_div is 1, else one in tick_div clks.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (tick_div <= 1) begin
                tick = 1'b1;
                cnt  = 0;
            end else begin
                tick = (cnt == 0);
                cnt  = (cnt + 1) % tick_div;
            end
        end
    end

    // Hold the line at v for n_bits bit periods.
    task automatic hold(input logic v, input int n_bits);
        rx_line = v;
        repeat (n_bits * OS * tick_div) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic sbit);
        exp_t e;
        e.d  = data;
        e.fe = ~sbit;
        e.pe = ((^data) ^ pbit) != 1'b0;
        q0.push_back(e);
        e.pe = ((^data) ^ pbit) != 1'b1;
        q1.push_back(e);
        hold(1'b0, 1);
        for (int i = 0; i < 8; i++) hold(data[i], 1);
        hold(pbit, 1);
        hold(sbit, 1);
    endtask

    task automatic take(input int id, input logic [7:0] d, input logic pe,
                        input logic fe, input logic busy);
        exp_t e;
        int   n;
        n = (id == 0) ? q0.size() : q1.size();
        check($sformatf("dut%0d_valid_expected", id), 32'(n > 0), 32'd1);
        if (n > 0) begin
            e = (id == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("dut%0d_data", id), 32'(d), 32'(e.d));
            check($sformatf("dut%0d_parity_err", id), 32'(pe), 32'(e.pe));
            check($sformatf("dut%0d_frame_err", id), 32'(fe), 32'(e.fe));
            check($sformatf("dut%0d_busy_at_valid", id), 32'(busy), 32'(e.fe));
        end
        $display("[TB] dut%0d frame data=%02h perr=%0b ferr=%0b busy=%0b", id, d, pe, fe, busy);
    endtask

    // Monitor: every rx_valid pulse must match the next expected frame.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (if0.rx_valid) take(0, if0.rx_data, if0.parity_err, if0.frame_err, if0.rx_busy);
            if (if1.rx_valid) take(1, if1.rx_data, if1.parity_err, if1.frame_err, if1.rx_busy);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_dut0_data"},  32'(if0.rx_data),    32'd0);
        check({tag, "_dut0_valid"}, 32'(if0.rx_valid),   32'd0);
        check({tag, "_dut0_perr"},  32'(if0.parity_err), 32'd0);
        check({tag, "_dut0_ferr"},  32'(if0.frame_err),  32'd0);
        check({tag, "_dut0_busy"},  32'(if0.rx_busy),    32'd0);
        check({tag, "_dut1_data"},  32'(if1.rx_data),    32'd0);
        check({tag, "_dut1_busy"},  32'(if1.rx_busy),    32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        // Reset state
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        hold(1'b1, 2);

        // Nominal frame, correct even parity
        send_frame(8'hA5, 1'b0, 1'b1);
        hold(1'b1, 2);

        // Parity bit 1: error for even receiver, good for odd receiver
        send_frame(8'hA5, 1'b1, 1'b1);
        hold(1'b1, 2);

        // Framing error, line stuck low afterwards
        send_frame(8'h3C, 1'b0, 1'b0);
        rx_line = 1'b0;
        repeat (40) @(negedge clk);
        check("recover_busy_dut0", 32'(if0.rx_busy), 32'd1);
        check("recover_busy_dut1", 32'(if1.rx_busy), 32'd1);
        rx_line = 1'b1;
        repeat (20) @(negedge clk);
        check("recover_exit_dut0", 32'(if0.rx_busy), 32'd0);
        hold(1'b1, 2);

        // Start glitch of 4 ticks
        rx_line = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_dut0", 32'(if0.rx_busy), 32'd1);
        rx_line = 1'b1;
        repeat (3 * OS) @(negedge clk);
        check("glitch_idle_dut0", 32'(if0.rx_busy), 32'd0);
        check("glitch_idle_dut1", 32'(if1.rx_busy), 32'd0);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        hold(1'b1, 2);

        // Reset during data bit 3: partial frame discarded
        hold(1'b0, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        repeat (OS / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 2);

        // Gapped ticks: one tick every 4 clks
        tick_div = 4;
        hold(1'b1, 1);
        send_frame(8'h5A, 1'b0, 1'b1);
        hold(1'b1, 2);

        // Randomised frames
        for (int k = 0; k < 30; k++) begin
            tick_div = int'($urandom_range(1, 4));
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s);
            if (!s) begin
                rx_line = 1'b0;
                repeat ($urandom_range(0, 50)) @(negedge clk);
                hold(1'b1, int'($urandom_range(1, 3)));
            end else begin
                hold(1'b1, int'($urandom_range(0, 2)));
            end
        end

        hold(1'b1, 3);
        check("pending_dut0", 32'(q0.size()), 32'd0);
        check("pending_dut1", 32'(q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
